// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event sequencer: parses E0/F0 prefixes from received bytes into
// {ext, brk, code} events buffered in a show-ahead FIFO, splitting off system bytes.
module ps2_key_event_ctrl #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_tick,
  output logic                     ev_valid,
  output logic [9:0]               ev_data,
  input  logic                     ev_rd,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     sys_tick,
  output logic [7:0]               sys_code,
  output logic                     ovf,
  output logic                     seq_err,
  input  logic                     clr_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              seq_err_q, seq_err_d;
  logic              sys_tick_q, sys_tick_d;
  logic [7:0]        sys_code_q, sys_code_d;
  logic [9:0]        mem_q [DEPTH];

  logic       is_sys, is_e0, is_f0;
  logic       push, sys_hit, err_set;
  logic [9:0] push_data;
  logic       full, empty, pop, wr_en, ovf_set;

  always_comb begin
    is_sys = rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    is_e0  = (rx_data == 8'hE0);
    is_f0  = (rx_data == 8'hF0);
  end

  // Sequence parser; an incoming byte always wins over a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = '0;
    sys_hit   = 1'b0;
    err_set   = 1'b0;
    if (rx_tick) begin
      if (is_sys) begin
        sys_hit = 1'b1;
        state_d = StIdle;
        err_set = (state_q != StIdle);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (is_e0) begin
              state_d = StE0;
            end else if (is_f0) begin
              state_d = StF0;
            end else begin
              push      = 1'b1;
              push_data = {2'b00, rx_data};
            end
          end
          StE0: begin
            if (is_f0) begin
              state_d = StE0F0;
            end else if (!is_e0) begin
              push      = 1'b1;
              push_data = {2'b10, rx_data};
              state_d   = StIdle;
            end
          end
          StF0, StE0F0: begin
            state_d = StIdle;
            if (is_e0 || is_f0) begin
              err_set = 1'b1;
            end else begin
              push      = 1'b1;
              push_data = {(state_q == StE0F0), 1'b1, rx_data};
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle && timer_q == TmrW'(TIMEOUT - 1)) begin
      state_d = StIdle;
      err_set = 1'b1;
    end
  end

  always_comb begin
    timer_d = (rx_tick || state_q == StIdle) ? '0 : timer_q + 1'b1;
  end

  // FIFO bookkeeping; a pop frees a slot for a push in the same cycle even when full.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    pop      = ev_rd && !empty;
    wr_en    = push && (!full || pop);
    ovf_set  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    ovf_d      = ovf_set | (ovf_q & ~clr_err);
    seq_err_d  = err_set | (seq_err_q & ~clr_err);
    sys_tick_d = sys_hit;
    sys_code_d = sys_hit ? rx_data : sys_code_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      sys_tick_q <= 1'b0;
      sys_code_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      seq_err_q  <= seq_err_d;
      sys_tick_q <= sys_tick_d;
      sys_code_q <= sys_code_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    ev_valid = !empty;
    ev_data  = empty ? '0 : mem_q[rd_ptr_q];
    ev_count = count_q;
    sys_tick = sys_tick_q;
    sys_code = sys_code_q;
    ovf      = ovf_q;
    seq_err  = seq_err_q;
  end

endmodule
